md_unit: RTL

Multi-cycle multiply/divide unit in the E stage of the MIPS pipeline, owning the HI/LO registers. It is the responder side of the `start`/`busy` handshake that the hazard unit consumes to stall `mfhi`/`mflo` and back-to-back mult/div in D. It accepts one operation per `start` strobe and holds `busy` for a fixed per-operation latency. It commits results to HI/LO atomically when the operation completes.

---
 rtl/md_pkg.sv | 72 +++++++
 rtl/md_if.sv | 16 +
 rtl/md_div_iter.sv | 103 ++++++++++
 rtl/md_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e      : operation encodings carried on md_op
//   - md_state_e   : control FSM states
//   - ITER_DIV_LAT : busy width of div/divu when the iterative divider is built
//   - helpers      : reference 64-bit multiply and 32-bit divide used at issue
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } md_state_e;

  localparam int unsigned ITER_DIV_LAT = 33;
  localparam int unsigned CNT_W        = 16;

  function automatic logic is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Low 64 bits of the product of the 64-bit extended operands equal the
  // true signed/unsigned 64-bit product.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{sgn & a[31]}}, a};
    bx = {{32{sgn & b[31]}}, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. Works on magnitudes so the
  // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic        a_neg;
    logic        b_neg;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    ma    = a_neg ? (32'd0 - a) : a;
    mb    = b_neg ? (32'd0 - b) : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (a_neg ^ b_neg) q = 32'd0 - q;
    if (a_neg)         r = 32'd0 - r;
    return {r, q};
  endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E-stage request / HI-LO result bundle of the multiply/divide unit.
//   start, flush, md_op, a, b : issue side (driven by decode)
//   busy, hi, lo              : unit state seen by the hazard unit and mfhi/mflo
interface md_if;
  logic        start;
  logic        flush;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, flush, md_op, a, b, input busy, hi, lo);
  modport slave  (input start, flush, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_div_iter.sv
// md_div_iter: radix-2 restoring divider, one quotient bit per cycle.
//   clk, reset_n        : clock, async active-low reset
//   start               : setup strobe; latches operand magnitudes and signs
//   sgn                 : treat operands as signed
//   dividend, divisor   : operands, sampled with start
//   done                : one-cycle pulse when quot/rem are valid
//   quot, rem           : sign-corrected results (valid while done)
// Setup happens on the start edge, then 32 iterations; done is high in the
// cycle after the last iteration.
module md_div_iter
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [5:0]  iter_q, iter_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

  logic        a_neg;
  logic        b_neg;
  logic [32:0] rem_sh;
  logic [33:0] diff;

  assign a_neg  = sgn & dividend[31];
  assign b_neg  = sgn & divisor[31];
  // Dividend bits shift out of quot_q into the partial remainder.
  assign rem_sh = {rem_q, quot_q[31]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};

  always_comb begin
    active_d = active_q;
    done_d   = 1'b0;
    iter_d   = iter_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    if (start) begin
      active_d = 1'b1;
      iter_d   = 6'd32;
      rem_d    = 32'd0;
      quot_d   = a_neg ? (32'd0 - dividend) : dividend;
      dvs_d    = b_neg ? (32'd0 - divisor) : divisor;
      q_neg_d  = a_neg ^ b_neg;
      r_neg_d  = a_neg;
    end else if (active_q) begin
      if (!diff[33]) begin
        rem_d  = diff[31:0];
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = rem_sh[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
      iter_d = iter_q - 6'd1;
      if (iter_q == 6'd1) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      iter_q   <= 6'd0;
      rem_q    <= 32'd0;
      quot_q   <= 32'd0;
      dvs_q    <= 32'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  assign done = done_q;
  assign quot = q_neg_q ? (32'd0 - quot_q) : quot_q;
  assign rem  = r_neg_q ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk, reset_n : clock, async active-low reset
//   bus          : md_if slave (start/flush/md_op/a/b in; busy/hi/lo out)
// Parameters: MUL_LAT busy cycles for mult/multu, DIV_LAT for div/divu.
// Build option MD_ITER_DIV_EN: div/divu go through md_div_iter and take
// ITER_DIV_LAT cycles (DIV_LAT ignored). Results are identical either way.
// HI/LO commit together on the edge that drops busy, so a cleared busy never
// shows stale results.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input logic clk,
  input logic reset_n,
  md_if.slave bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic             bzero_q, bzero_d;
  logic [63:0]      res_q, res_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  md_op_e           op_in;
  logic             accept;
  logic             issue;
  logic             last;
  logic [63:0]      commit_res;
  logic [CNT_W-1:0] lat;

  assign op_in  = md_op_e'(bus.md_op);
  assign accept = bus.start & ~bus.flush;
  assign issue  = accept && (state_q == StIdle) && (is_mul(op_in) || is_div(op_in));

`ifdef MD_ITER_DIV_EN
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  md_div_iter u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (issue && is_div(op_in)),
    .sgn      (op_in == MD_DIV),
    .dividend (bus.a),
    .divisor  (bus.b),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  assign lat        = is_mul(op_in) ? CNT_W'(MUL_LAT) : CNT_W'(ITER_DIV_LAT);
  assign commit_res = is_div(op_q) ? {div_rem, div_quot} : res_q;
  assign last       = is_div(op_q) ? div_done : (cnt_q == CNT_W'(1));
`else
  assign lat        = is_mul(op_in) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
  assign commit_res = res_q;
  assign last       = (cnt_q == CNT_W'(1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    bzero_d = bzero_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // mthi/mtlo act in any state; a commit in the same cycle overrides below.
    if (accept && (op_in == MD_MTHI)) hi_d = bus.a;
    if (accept && (op_in == MD_MTLO)) lo_d = bus.a;

    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StRun;
          cnt_d   = lat;
          op_d    = op_in;
          bzero_d = (bus.b == 32'd0);
`ifdef MD_ITER_DIV_EN
          res_d   = mul64(bus.a, bus.b, op_in == MD_MULT);
`else
          res_d   = is_mul(op_in) ? mul64(bus.a, bus.b, op_in == MD_MULT)
                                  : div64(bus.a, bus.b, op_in == MD_DIV);
`endif
        end
      end
      StRun: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          state_d = StIdle;
          // Divide by zero leaves HI/LO untouched.
          if (!(is_div(op_q) && bzero_q)) begin
            hi_d = commit_res[63:32];
            lo_d = commit_res[31:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      bzero_q <= 1'b0;
      res_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      bzero_q <= bzero_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
